// File: rtl/button_capture.sv
// button_capture: synchronizes and debounces four colour buttons and holds
// the first press in a one-deep event register read/cleared at address ADDR.
//
// Read/acknowledge protocol: a read (mem_addr==ADDR, mem_wren=0) raises
// rd_hit combinationally and presents {overflow, valid, colour} on rd_data
// with no side effect; a write to ADDR is the acknowledge and clears the
// event register on that same edge, while an event arriving on that edge is
// still captured into the freshly cleared register.
module button_capture #(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [11:0] ADDR            = 12'd7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  btn_raw,
  input  logic [11:0] mem_addr,
  input  logic        mem_wren,
  output logic        rd_hit,
  output logic [31:0] rd_data,
  output logic        press_pending
);

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic [3:0]  s1;
  logic [3:0]  s2;
  logic [3:0]  stable;
  logic [3:0]  stable_nxt;
  logic [15:0] cnt     [4];
  logic [15:0] cnt_nxt [4];
  logic [3:0]  rise;
  logic [1:0]  winner;
  logic        multi;
  logic        ack;
  logic        ev_valid;
  logic        ev_overflow;
  logic [1:0]  ev_colour;

  // Two-flop synchronizer for the asynchronous button levels.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 4'b0;
      s2 <= 4'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Per-button debounce: accept a new level after DEBOUNCE_CYCLES mismatches in a row.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stable_nxt[i] = stable[i];
      cnt_nxt[i]    = 16'd0;
      if (s2[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) begin
          stable_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 16'd1;
        end
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      stable <= 4'b0;
      for (int i = 0; i < 4; i++) cnt[i] <= 16'd0;
    end else begin
      stable <= stable_nxt;
      for (int i = 0; i < 4; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // Press events, lowest index wins, and detection of simultaneous presses.
  always_comb begin
    rise   = stable_nxt & ~stable;
    multi  = |(rise & (rise - 4'd1));
    winner = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rise[i]) winner = 2'(i);
    end
  end

  assign ack = mem_wren && (mem_addr == ADDR);

  // Event register: acknowledge clears first, then any event lands on top.
  always_ff @(posedge clock) begin
    if (reset) begin
      ev_valid    <= 1'b0;
      ev_overflow <= 1'b0;
      ev_colour   <= 2'd0;
    end else if (rise != 4'b0) begin
      if (ev_valid && !ack) begin
        ev_overflow <= 1'b1;
      end else begin
        ev_valid    <= 1'b1;
        ev_colour   <= winner;
        ev_overflow <= multi;
      end
    end else if (ack) begin
      ev_valid    <= 1'b0;
      ev_overflow <= 1'b0;
      ev_colour   <= 2'd0;
    end
  end

  // Zero-latency read decode and read data.
  always_comb begin
    rd_hit  = (mem_addr == ADDR) && !mem_wren;
    rd_data = {28'd0, ev_overflow, ev_valid, ev_colour};
  end

  assign press_pending = ev_valid;

endmodule

// File: tb/tb_button_capture.sv
// tb_button_capture: directed test-plan scenarios plus random button/bus
// traffic, checked against a sample-window reference model via a scoreboard.
module tb_button_capture;

  localparam int D = 4;
  localparam int W = 34;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  btn_raw;
  logic [11:0] mem_addr;
  logic        mem_wren;
  logic        rd_hit;
  logic [31:0] rd_data;
  logic        press_pending;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  bit armed    = 0;

  // Reference model: history of raw samples per edge and the event register.
  logic [3:0] hist[$];
  logic [3:0] m_stable;
  logic       m_valid;
  logic       m_ovf;
  logic [1:0] m_col;

  button_capture #(.DEBOUNCE_CYCLES(D), .ADDR(12'd7)) dut (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .mem_addr(mem_addr),
    .mem_wren(mem_wren), .rd_hit(rd_hit), .rd_data(rd_data),
    .press_pending(press_pending)
  );

  // Clock.
  always #5 clock = ~clock;

  // A level is accepted once the D samples seen two edges late all differ from it.
  task automatic model_edge(input logic rst, input logic [3:0] raw, input logic ack);
    logic [3:0] rises;
    logic       all_diff;
    if (rst) begin
      hist.delete();
      for (int k = 0; k < D + 2; k++) hist.push_back(4'b0);
      m_stable = 4'b0;
      m_valid  = 1'b0;
      m_ovf    = 1'b0;
      m_col    = 2'd0;
    end else begin
      hist.push_back(raw);
      void'(hist.pop_front());
      rises = 4'b0;
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++) begin
          if (hist[k][i] == m_stable[i]) all_diff = 1'b0;
        end
        if (all_diff) begin
          if (!m_stable[i]) rises[i] = 1'b1;
          m_stable[i] = ~m_stable[i];
        end
      end
      if (ack) begin
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_col   = 2'd0;
      end
      if (rises != 4'b0) begin
        if (m_valid) begin
          m_ovf = 1'b1;
        end else begin
          m_valid = 1'b1;
          m_ovf   = ($countones(rises) > 1);
          for (int i = 3; i >= 0; i--) if (rises[i]) m_col = 2'(i);
        end
      end
    end
  endtask

  // One bus cycle: drive inputs, queue the expected outputs, advance the model.
  task automatic cyc(input logic rst, input logic [3:0] raw,
                     input logic [11:0] addr, input logic wr);
    reset    = rst;
    btn_raw  = raw;
    mem_addr = addr;
    mem_wren = wr;
    if (armed)
      exp_q.push_back({(addr == 12'd7) && !wr, m_valid, 28'd0, m_ovf, m_valid, m_col});
    @(posedge clock);
    model_edge(rst, raw, wr && (addr == 12'd7));
    #1;
  endtask

  task automatic idle(input logic [3:0] raw, input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, raw, 12'd0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] raw, input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, raw, 12'd7, 1'b0);
  endtask

  task automatic ack_w(input logic [3:0] raw);
    cyc(1'b0, raw, 12'd7, 1'b1);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clock) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {rd_hit, press_pending, rd_data};
      n_checks++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL cycle_check t=%0t got hit=%b pend=%b data=%h want hit=%b pend=%b data=%h",
                    $time, act_v[33], act_v[32], act_v[31:0], exp_v[33], exp_v[32], exp_v[31:0]);
    end
  end

  // Stimulus.
  initial begin
    logic [3:0] raw_r;
    int op;
    cyc(1'b1, 4'b0, 12'd0, 1'b0);
    armed = 1;
    rd(4'b0, 2);

    // Clean press of green, read twice.
    idle(4'b0100, D + 3);
    rd(4'b0100, 2);
    ack_w(4'b0100);
    idle(4'b0, D + 4);
    rd(4'b0, 1);

    // Bounce on red, then a long hold, then a long release.
    idle(4'b0001, 1); idle(4'b0, 1);
    idle(4'b0001, 2); idle(4'b0, 1);
    idle(4'b0001, 3); idle(4'b0, 1);
    idle(4'b0001, 10);
    rd(4'b0001, 1);
    idle(4'b0, 10);
    rd(4'b0, 1);
    ack_w(4'b0);

    // Yellow pending, then blue: overflow.
    idle(4'b1000, D + 4);
    idle(4'b1010, D + 4);
    rd(4'b1010, 1);
    ack_w(4'b1010);
    rd(4'b1010, 1);
    idle(4'b0, D + 4);

    // Blue and yellow on the same edge.
    idle(4'b1010, D + 4);
    rd(4'b1010, 1);
    ack_w(4'b1010);
    idle(4'b0, D + 4);

    // Acknowledge on the exact edge green debounces.
    idle(4'b0100, D + 1);
    ack_w(4'b0100);
    rd(4'b0100, 2);
    ack_w(4'b0100);
    idle(4'b0, D + 4);

    // Reset with red pending and green mid-count.
    idle(4'b0001, D + 4);
    idle(4'b0100, 3);
    cyc(1'b1, 4'b0100, 12'd7, 1'b0);
    rd(4'b0100, D + 3);
    cyc(1'b0, 4'b0100, 12'd5, 1'b0);
    ack_w(4'b0);
    idle(4'b0, D + 4);

    // Random traffic.
    raw_r = 4'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) raw_r[$urandom_range(0, 3)] ^= 1'b1;
      op = $urandom_range(0, 299);
      if (op == 0)       cyc(1'b1, raw_r, 12'd7, 1'b0);
      else if (op < 20)  ack_w(raw_r);
      else if (op < 100) rd(raw_r, 1);
      else if (op < 120) cyc(1'b0, raw_r, 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
      else               idle(raw_r, 1);
    end

    repeat (2) @(negedge clock);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain got %0d pending want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_capture.md
# button_capture

Memory-mapped push-button input for the Sly Man Says game: synchronizes and debounces four colour buttons and holds the first press in a one-deep event register. It sits on the data-memory read path beside the LFSR read at address 5 and feeds the processor's `q_dmem` mux. `lw` from address 7 returns the pending press. `sw` to address 7 acknowledges and clears it. Button/colour encoding matches the `light_up` LED block: 0 red, 1 blue, 2 green, 3 yellow.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before a button level change is accepted; legal range 2..65535.
- `ADDR`, 12'd7: data-memory address decoded by this block.
- `clock`  in  1: system clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high; one clock with `reset`=1 clears all state.
- `btn_raw`  in  4: asynchronous, bouncing button levels, 1 = pressed; bit i = colour i.
- `mem_addr`  in  12: processor `address_dmem[11:0]`.
- `mem_wren`  in  1: processor `wren`.
- `rd_hit`  out  1: combinational; 1 when `mem_addr`==`ADDR` and `mem_wren`=0. The top level selects `rd_data` onto `q_dmem` when this is 1.
- `rd_data`  out  32: combinational read value:
  - bits 31:4 = 0.
  - bit 3 = overflow.
  - bit 2 = valid.
  - bits 1:0 = colour.
- `press_pending`  out  1: registered copy of valid.

## Operation
- **Synchronizer:** two flops per button, `s1`<=`btn_raw` and `s2`<=`s1`. Only `s2` is used downstream.
- **Debounce, per button:**
  - State: level `stable[i]` and a 16-bit counter `cnt[i]`.
  - If `s2[i]`==`stable[i]`: `cnt[i]`<=0.
  - Otherwise, if `cnt[i]`==`DEBOUNCE_CYCLES`-1: `stable[i]`<=`s2[i]` and `cnt[i]`<=0.
  - Otherwise: `cnt[i]`<=`cnt[i]`+1.
- **Press event:** `stable[i]` rising (0→1) in a given cycle. Releases generate no event.
- **Same-cycle priority:** if several buttons produce events in the same cycle, the lowest index wins (red > blue > green > yellow). The others are treated as overflow.
- **Event register** `{valid, colour, overflow}`:
  - Event while valid=0: valid<=1, colour<=winning index.
  - Event while valid=1: colour unchanged, overflow<=1.
  - More than one simultaneous event while valid=0: capture the winner, overflow<=1.
- **Acknowledge:**
  - `mem_wren`=1 and `mem_addr`==`ADDR` clears valid, colour and overflow at that edge. Write data is ignored.
  - If an event occurs in the same cycle as an acknowledge, the event is captured into the freshly cleared register (valid=1, new colour, overflow=0). The acknowledge never drops a new event.
- **Read side effects:** none. Repeated reads return the same value until acknowledged.
- **Reset:** all outputs and state are 0: `s1`, `s2`, `stable`, `cnt`, valid, colour, overflow, `press_pending`. Combinational `rd_data` is therefore 0 after reset (while `rd_hit`=1). A button already held through reset must still debounce and then produces one event.

## Timing
- `btn_raw[i]` rises before edge 0 and stays high:
  - `s1` high after edge 1, `s2` high after edge 2.
  - Mismatch edges are 3 .. 2+`DEBOUNCE_CYCLES`.
  - `stable`, valid and `press_pending` go high after edge 2+`DEBOUNCE_CYCLES`.
- A pulse on `btn_raw` (as seen at `s2`) shorter than `DEBOUNCE_CYCLES` cycles leaves `stable` unchanged and produces no event. Any single-cycle return to the stable level restarts the count.
- `rd_data` and `rd_hit` follow `mem_addr`/`mem_wren` with zero latency. The event register state read in cycle n reflects updates through edge n.
- The acknowledge takes effect on the same edge as the `sw`. A `lw` in the next cycle reads 0 unless a new event arrived.
- `reset` mid-debounce or with an event pending clears everything at that edge. No event is emitted for the interrupted press.

## Test plan
- **Clean press** (`DEBOUNCE_CYCLES`=4): hold `btn_raw`=4'b0100 from before edge 0.
  - valid=0 through edge 5; after edge 6, `press_pending`=1.
  - `mem_addr`=7, `mem_wren`=0 gives `rd_hit`=1, `rd_data`=32'h6.
  - Reading again gives 32'h6.
- **Bounce:** toggle bit 0 with high runs of 1, 2 and 3 cycles, then hold high for 10.
  - Exactly one event; `rd_data`=32'h4.
  - Subsequent release and 10 cycles low: `rd_data` stays 32'h4.
- **Acknowledge and overflow:**
  - Press yellow, then while still pending press blue: `rd_data`=32'hF.
  - `sw` to 7: next-cycle `rd_data`=0, `press_pending`=0.
- **Simultaneous:** bits 1 and 3 debounce on the same edge → `rd_data`=32'hD (blue, overflow).
- **Acknowledge collision:** `sw` to 7 on the exact edge green's event occurs → after that edge `rd_data`=32'h6, overflow=0.
- **Reset mid-operation:**
  - `reset` pulsed while red has a pending event and green is mid-count → all zero after that edge.
  - Green still held afterwards produces its event 2+`DEBOUNCE_CYCLES` edges after `reset` falls.
  - `mem_addr`≠7 gives `rd_hit`=0.
